// File: rtl/cpu_pkg.sv
// Shared definitions for the EX stage: ALU/mul-div opcodes, control bit
// positions of the ID/EX register, mul/div FSM states and forwarding helper.
package cpu_pkg;

  // ALU control codes (id_ex[3:0])
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;

  // Multiply/divide unit operations
  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MFHI  = 3'b101;
  localparam logic [2:0] MD_MFLO  = 3'b110;
  localparam logic [2:0] MD_RSVD  = 3'b111;

  // Control bit positions inside the ID/EX control fields
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int M_MEMREAD   = 1;
  localparam int EX_ALUCTR_LSB = 0;
  localparam int EX_ALUCTR_MSB = 3;
  localparam int EX_ALUSRCA  = 4;
  localparam int EX_ALUSRCB  = 5;
  localparam int EX_REGDST   = 6;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Operations that launch an iterative multiply or divide
  function automatic logic md_is_start(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Operations that depend on the unit (launch or read HI/LO)
  function automatic logic md_is_access(input logic [2:0] op);
    return md_is_start(op) || (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // Operand forwarding: MEM beats WB, register 0 never forwards
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] rf_data,
    input logic        mem_we,
    input logic [4:0]  mem_idx,
    input logic [31:0] mem_val,
    input logic        wb_we,
    input logic [4:0]  wb_idx,
    input logic [31:0] wb_val
  );
    logic [31:0] r;
    if (mem_we && (mem_idx != 5'd0) && (mem_idx == idx)) begin
      r = mem_val;
    end else if (wb_we && (wb_idx != 5'd0) && (wb_idx == idx)) begin
      r = wb_val;
    end else begin
      r = rf_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle of ID/EX inputs, forwarding inputs and EX/MEM outputs of the EX stage.
interface ex_stage_if;
  logic [1:0]  id_wb;
  logic [1:0]  id_m;
  logic [6:0]  id_ex;
  logic [2:0]  md_op;
  logic [31:0] pc_plus_4;
  logic [31:0] signext;
  logic [31:0] zeroext;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mem_regwrite;
  logic        wb_regwrite;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic [31:0] mem_result;
  logic [31:0] wb_result;
  logic [1:0]  ex_wb_out;
  logic [1:0]  ex_m_out;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        md_stall;

  // Pipeline side feeding the EX stage
  modport master (
    output id_wb, id_m, id_ex, md_op, pc_plus_4, signext, zeroext,
           rd, rs, rt, rs_data, rt_data, mem_regwrite, wb_regwrite,
           mem_rd, wb_rd, mem_result, wb_result,
    input  ex_wb_out, ex_m_out, alu_result, store_data, dest_reg, md_stall
  );

  // EX stage itself
  modport slave (
    input  id_wb, id_m, id_ex, md_op, pc_plus_4, signext, zeroext,
           rd, rs, rt, rs_data, rt_data, mem_regwrite, wb_regwrite,
           mem_rd, wb_rd, mem_result, wb_result,
    output ex_wb_out, ex_m_out, alu_result, store_data, dest_reg, md_stall
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO registers and the
// front-end stall for instructions that hit it while it is busy.
module muldiv_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        md_stall_o
);

  md_state_e   state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [63:0] work_q, work_d;     // {acc/remainder, multiplier/quotient}
  logic        is_mul_q, is_mul_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op_s;
  logic        sa_s, sb_s;
  logic [31:0] ma_s, mb_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_sh_s;
  logic [32:0] div_diff_s;
  logic        div_ge_s;
  logic [63:0] div_next_s;
  logic [63:0] mul_res_s;
  logic [31:0] div_lo_s;
  logic [31:0] div_hi_s;

  // Operand magnitudes and signs for a launch this cycle
  assign signed_op_s = (md_op_i == MD_MULT) || (md_op_i == MD_DIV);
  assign sa_s = signed_op_s & rs_val_i[31];
  assign sb_s = signed_op_s & rt_val_i[31];
  assign ma_s = sa_s ? (~rs_val_i + 32'd1) : rs_val_i;
  assign mb_s = sb_s ? (~rt_val_i + 32'd1) : rt_val_i;

  // One shift-add multiply step
  assign mul_sum_s  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_next_s = {mul_sum_s, work_q[31:1]};

  // One restoring divide step
  assign div_sh_s   = work_q[63:31];
  assign div_diff_s = div_sh_s - {1'b0, mcand_q};
  assign div_ge_s   = (div_sh_s >= {1'b0, mcand_q});
  assign div_next_s = div_ge_s ? {div_diff_s[31:0], work_q[30:0], 1'b1}
                               : {div_sh_s[31:0],   work_q[30:0], 1'b0};

  // Sign-corrected results; a zero divisor leaves the dividend as remainder
  assign mul_res_s = neg_lo_q ? (~work_q + 64'd1) : work_q;
  assign div_lo_s  = dz_q ? 32'hFFFF_FFFF
                          : (neg_lo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0]);
  assign div_hi_s  = neg_hi_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];

  // Next-state logic for the mul/div sequencer
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    work_d   = work_q;
    is_mul_d = is_mul_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (md_is_start(md_op_i)) begin
          state_d  = MD_BUSY;
          count_d  = 5'd0;
          neg_lo_d = sa_s ^ sb_s;
          neg_hi_d = sa_s;
          if ((md_op_i == MD_MULT) || (md_op_i == MD_MULTU)) begin
            is_mul_d = 1'b1;
            dz_d     = 1'b0;
            mcand_d  = ma_s;
            work_d   = {32'd0, mb_s};
          end else begin
            is_mul_d = 1'b0;
            dz_d     = (rt_val_i == 32'd0);
            mcand_d  = mb_s;
            work_d   = {32'd0, ma_s};
          end
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        work_d  = is_mul_q ? mul_next_s : div_next_s;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = MD_FIX;
        end else begin
          state_d = MD_BUSY;
        end
      end
      MD_FIX: begin
        if (is_mul_q) begin
          hi_d = mul_res_s[63:32];
          lo_d = mul_res_s[31:0];
        end else begin
          hi_d = div_hi_s;
          lo_d = div_lo_s;
        end
        count_d = 5'd0;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        count_d = 5'd0;
      end
    endcase
  end

  // State, counter, operand latches and HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      count_q  <= 5'd0;
      mcand_q  <= 32'd0;
      work_q   <= 64'd0;
      is_mul_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      work_q   <= work_d;
      is_mul_q <= is_mul_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign md_stall_o = (state_q != MD_IDLE) && md_is_access(md_op_i);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, HI/LO readout and the
// EX/MEM control bubble while the mul/div unit holds the front end.
module ex_stage
  import cpu_pkg::*;
(
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);

  logic [31:0] fwd_a_s, fwd_b_s;
  logic [31:0] op_a_s, op_b_s;
  logic [3:0]  alu_ctr_s;
  logic [31:0] alu_raw_s;
  logic [31:0] alu_out_s;
  logic [31:0] hi_s, lo_s;
  logic        md_stall_s;
  logic [1:0]  wb_out_s, m_out_s;
  logic        unused_pc_s;

  assign unused_pc_s = ^bus.pc_plus_4;

  assign alu_ctr_s = bus.id_ex[EX_ALUCTR_MSB:EX_ALUCTR_LSB];

  assign fwd_a_s = fwd_sel(bus.rs, bus.rs_data, bus.mem_regwrite, bus.mem_rd,
                           bus.mem_result, bus.wb_regwrite, bus.wb_rd, bus.wb_result);
  assign fwd_b_s = fwd_sel(bus.rt, bus.rt_data, bus.mem_regwrite, bus.mem_rd,
                           bus.mem_result, bus.wb_regwrite, bus.wb_rd, bus.wb_result);

  // ALU operand selection; logical immediates use the zero-extended form
  always_comb begin
    if (bus.id_ex[EX_ALUSRCA]) begin
      op_a_s = {27'd0, bus.signext[10:6]};
    end else begin
      op_a_s = fwd_a_s;
    end
    if (!bus.id_ex[EX_ALUSRCB]) begin
      op_b_s = fwd_b_s;
    end else if ((alu_ctr_s == ALU_AND) || (alu_ctr_s == ALU_OR) || (alu_ctr_s == ALU_XOR)) begin
      op_b_s = bus.zeroext;
    end else begin
      op_b_s = bus.signext;
    end
  end

  // ALU function decode
  always_comb begin
    alu_raw_s = 32'd0;
    case (alu_ctr_s)
      ALU_AND:  alu_raw_s = op_a_s & op_b_s;
      ALU_OR:   alu_raw_s = op_a_s | op_b_s;
      ALU_ADD:  alu_raw_s = op_a_s + op_b_s;
      ALU_XOR:  alu_raw_s = op_a_s ^ op_b_s;
      ALU_NOR:  alu_raw_s = ~(op_a_s | op_b_s);
      ALU_SUB:  alu_raw_s = op_a_s - op_b_s;
      ALU_SLT:  alu_raw_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
      ALU_SLTU: alu_raw_s = {31'd0, (op_a_s < op_b_s)};
      ALU_SLL:  alu_raw_s = op_b_s << op_a_s[4:0];
      ALU_SRL:  alu_raw_s = op_b_s >> op_a_s[4:0];
      ALU_SRA:  alu_raw_s = $signed(op_b_s) >>> op_a_s[4:0];
      ALU_LUI:  alu_raw_s = {op_b_s[15:0], 16'd0};
      default:  alu_raw_s = 32'd0;
    endcase
  end

  muldiv_unit u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .md_op_i    (bus.md_op),
    .rs_val_i   (fwd_a_s),
    .rt_val_i   (fwd_b_s),
    .hi_o       (hi_s),
    .lo_o       (lo_s),
    .md_stall_o (md_stall_s)
  );

  // Result mux and EX/MEM control; stalled or launching mul/div writes nothing
  always_comb begin
    if (bus.md_op == MD_MFHI) begin
      alu_out_s = hi_s;
    end else if (bus.md_op == MD_MFLO) begin
      alu_out_s = lo_s;
    end else begin
      alu_out_s = alu_raw_s;
    end
    if (md_stall_s || md_is_start(bus.md_op)) begin
      wb_out_s = 2'b00;
      m_out_s  = 2'b00;
    end else begin
      wb_out_s = bus.id_wb;
      m_out_s  = bus.id_m;
    end
  end

  assign bus.alu_result = alu_out_s;
  assign bus.store_data = fwd_b_s;
  assign bus.dest_reg   = bus.id_ex[EX_REGDST] ? bus.rd : bus.rt;
  assign bus.ex_wb_out  = wb_out_s;
  assign bus.ex_m_out   = m_out_s;
  assign bus.md_stall   = md_stall_s;

endmodule
